// File: rtl/ddr_prbs_pkg.sv
// Shared types and PRBS helpers for the multi-lane PRBS read-back checker.
// Supported polynomials: x^7+x^6+1, x^15+x^14+1, x^23+x^18+1, x^31+x^28+1.
package ddr_prbs_pkg;

    localparam int unsigned MAX_LANE_W = 128;
    localparam int unsigned PIDX_W     = $clog2(MAX_LANE_W);
    localparam int unsigned SIDX_W     = $clog2(2 * MAX_LANE_W);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } lane_state_e;

    // Second feedback tap of the polynomial x^ord + x^tap + 1.
    function automatic int unsigned prbs_tap(input int unsigned ord);
        int unsigned tap;
        case (ord)
            7:       tap = 6;
            15:      tap = 14;
            23:      tap = 18;
            default: tap = 28;
        endcase
        return tap;
    endfunction

    // Predicts the next lane_w-bit word from the previous one. The word MSB is
    // the earliest bit on the wire, so s[k] walks the stream in time order.
    function automatic logic [MAX_LANE_W-1:0] prbs_next(
        input logic [MAX_LANE_W-1:0] prev,
        input int unsigned           lane_w,
        input int unsigned           ord
    );
        logic [2*MAX_LANE_W-1:0] s;
        logic [MAX_LANE_W-1:0]   nxt;
        int unsigned             tap;
        tap = prbs_tap(ord);
        s   = '0;
        nxt = '0;
        for (int unsigned k = 0; k < 2 * MAX_LANE_W; k++) begin
            if (k < lane_w)
                s[SIDX_W'(k)] = prev[PIDX_W'(lane_w - 1 - k)];
            else if (k < 2 * lane_w)
                s[SIDX_W'(k)] = s[SIDX_W'(k - ord)] ^ s[SIDX_W'(k - tap)];
        end
        for (int unsigned j = 0; j < MAX_LANE_W; j++) begin
            if (j < lane_w)
                nxt[PIDX_W'(j)] = s[SIDX_W'(2 * lane_w - 1 - j)];
        end
        return nxt;
    endfunction

endpackage

// File: rtl/ddr_prbs_lane_chk.sv
// Single-lane self-synchronising PRBS checker with HUNT/LOCK tracking and
// saturating statistics. DDR_PRBS_BITERR_EN makes ecnt accumulate bit errors.
module ddr_prbs_lane_chk
    import ddr_prbs_pkg::*;
#(
    parameter int unsigned LANE_W   = 32,
    parameter int unsigned PRBS_ORD = 31,
    parameter int unsigned SYNC_THR = 8,
    parameter int unsigned LOSS_THR = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              vld,
    input  logic [LANE_W-1:0] data,
    input  logic              stat_clr,
    output logic              lock,
    output logic              err_flag,
    output logic [CNT_W-1:0]  dcnt,
    output logic [CNT_W-1:0]  ecnt
);

    localparam int unsigned MW = $clog2(SYNC_THR + 1);
    localparam int unsigned LW = $clog2(LOSS_THR + 1);

    lane_state_e       state, state_nxt;
    logic [MW-1:0]     match_cnt, match_nxt;
    logic [LW-1:0]     loss_cnt, loss_nxt;
    logic [LANE_W-1:0] hist;
    logic              hist_vld;
    logic [LANE_W-1:0] expected;
    logic              cmp;
    logic              mis;
    logic              cnt_en;
    logic [CNT_W-1:0]  ecnt_nxt;

    assign expected = LANE_W'(prbs_next(MAX_LANE_W'(hist), LANE_W, PRBS_ORD));
    assign cmp      = vld & hist_vld;
    assign mis      = (data != expected);
    assign cnt_en   = cmp && (state == LOCK);
    assign lock     = (state == LOCK);

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        loss_nxt  = loss_cnt;
        if (cmp) begin
            case (state)
                HUNT: begin
                    if (mis) begin
                        match_nxt = '0;
                    end else if (match_cnt == MW'(SYNC_THR - 1)) begin
                        state_nxt = LOCK;
                        match_nxt = match_cnt + 1'b1;
                        loss_nxt  = '0;
                    end else begin
                        match_nxt = match_cnt + 1'b1;
                    end
                end
                LOCK: begin
                    if (!mis) begin
                        loss_nxt = '0;
                    end else if (loss_cnt == LW'(LOSS_THR - 1)) begin
                        state_nxt = HUNT;
                        loss_nxt  = loss_cnt + 1'b1;
                        match_nxt = '0;
                    end else begin
                        loss_nxt = loss_cnt + 1'b1;
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            match_cnt <= '0;
            loss_cnt  <= '0;
            hist      <= '0;
            hist_vld  <= 1'b0;
        end else begin
            state     <= state_nxt;
            match_cnt <= match_nxt;
            loss_cnt  <= loss_nxt;
            if (vld) begin
                hist     <= data;
                hist_vld <= 1'b1;
            end
        end
    end

`ifdef DDR_PRBS_BITERR_EN
    localparam int unsigned INC_W = $clog2(LANE_W + 1);
    logic [INC_W-1:0] inc;
    assign inc = INC_W'($countones(data ^ expected));
`else
    localparam int unsigned INC_W = 1;
    logic [INC_W-1:0] inc;
    assign inc = 1'b1;
`endif

    // One spare bit above the wider operand catches overflow for saturation.
    localparam int unsigned SUM_W = ((CNT_W > INC_W) ? CNT_W : INC_W) + 1;
    logic [SUM_W-1:0] ecnt_sum;
    assign ecnt_sum = SUM_W'(ecnt) + SUM_W'(inc);
    assign ecnt_nxt = (ecnt_sum[SUM_W-1:CNT_W] != '0) ? '1 : ecnt_sum[CNT_W-1:0];

    always_ff @(posedge clk_sys or negedge reset) begin
        if (!reset) begin
            dcnt     <= '0;
            ecnt     <= '0;
            err_flag <= 1'b0;
        end else if (stat_clr) begin
            dcnt     <= '0;
            ecnt     <= '0;
            err_flag <= 1'b0;
        end else if (cnt_en) begin
            if (dcnt != '1)
                dcnt <= dcnt + 1'b1;
            if (mis) begin
                ecnt     <= ecnt_nxt;
                err_flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ddr_prbs_mchk.sv
// Multi-lane PRBS read-back checker: CH_NUM independent lane checkers with
// packed status outputs. DDR_PRBS_BITERR_EN selects bit-error counting.
module ddr_prbs_mchk
    import ddr_prbs_pkg::*;
#(
    parameter int unsigned AXI_DATA_WIDTH = 512,
    parameter int unsigned LANE_W         = 32,
    parameter int unsigned PRBS_ORD       = 31,
    parameter int unsigned SYNC_THR       = 8,
    parameter int unsigned LOSS_THR       = 4,
    parameter int unsigned CNT_W          = 32,
    localparam int unsigned CH_NUM        = AXI_DATA_WIDTH / LANE_W
) (
    input  logic                      clk_sys,
    input  logic                      reset,
    input  logic                      prbs_vld_i,
    input  logic [AXI_DATA_WIDTH-1:0] prbs_data_i,
    input  logic                      stat_clr,
    output logic [CH_NUM-1:0]         prbs_lock,
    output logic [CH_NUM-1:0]         prbs_err_flag,
    output logic [CH_NUM*CNT_W-1:0]   prbs_rx_dcnt,
    output logic [CH_NUM*CNT_W-1:0]   prbs_rx_ecnt
);

    for (genvar i = 0; i < CH_NUM; i++) begin : g_lane
        ddr_prbs_lane_chk #(
            .LANE_W   (LANE_W),
            .PRBS_ORD (PRBS_ORD),
            .SYNC_THR (SYNC_THR),
            .LOSS_THR (LOSS_THR),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk_sys  (clk_sys),
            .reset    (reset),
            .vld      (prbs_vld_i),
            .data     (prbs_data_i[LANE_W*i +: LANE_W]),
            .stat_clr (stat_clr),
            .lock     (prbs_lock[i]),
            .err_flag (prbs_err_flag[i]),
            .dcnt     (prbs_rx_dcnt[CNT_W*i +: CNT_W]),
            .ecnt     (prbs_rx_ecnt[CNT_W*i +: CNT_W])
        );
    end

endmodule

// File: tb/tb_ddr_prbs_mchk.sv
// Directed bench for ddr_prbs_mchk: default 16x32 PRBS31 instance plus small
// parameter variants, fed by an independent bit-serial PRBS generator.
module tb_ddr_prbs_mchk;

    localparam int NL = 24;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic vld     = 1'b0;
    logic clr     = 1'b0;

    always #5 clk_sys = ~clk_sys;

    // main: 512/32/ord31 ; a: 32/16/ord7/CNT_W4 ; b: 32/16/ord15 ; c: 128/64/ord23 ; d: 128/64/ord31
    logic [511:0] data_m;
    logic [31:0]  data_a, data_b;
    logic [127:0] data_c, data_d;
    logic [15:0]  lock_m, err_m;
    logic [1:0]   lock_a, err_a, lock_b, err_b, lock_c, err_c, lock_d, err_d;
    logic [511:0] dcnt_m, ecnt_m;
    logic [7:0]   dcnt_a, ecnt_a;
    logic [63:0]  dcnt_b, ecnt_b, dcnt_c, ecnt_c, dcnt_d, ecnt_d;

    logic [31:0] wm [16];
    logic [15:0] wa [2];
    logic [15:0] wb [2];
    logic [63:0] wc [2];
    logic [63:0] wd [2];
    logic [31:0] dc_m [16];
    logic [31:0] ec_m [16];
    logic [3:0]  dc_a [2];
    logic [3:0]  ec_a [2];

    for (genvar g = 0; g < 16; g++) begin : g_m
        assign data_m[32*g +: 32] = wm[g];
        assign dc_m[g] = dcnt_m[32*g +: 32];
        assign ec_m[g] = ecnt_m[32*g +: 32];
    end
    for (genvar g = 0; g < 2; g++) begin : g_s
        assign data_a[16*g +: 16] = wa[g];
        assign data_b[16*g +: 16] = wb[g];
        assign data_c[64*g +: 64] = wc[g];
        assign data_d[64*g +: 64] = wd[g];
        assign dc_a[g] = dcnt_a[4*g +: 4];
        assign ec_a[g] = ecnt_a[4*g +: 4];
    end

    ddr_prbs_mchk dut_m (
        .clk_sys(clk_sys), .reset(reset), .prbs_vld_i(vld), .prbs_data_i(data_m), .stat_clr(clr),
        .prbs_lock(lock_m), .prbs_err_flag(err_m), .prbs_rx_dcnt(dcnt_m), .prbs_rx_ecnt(ecnt_m));

    ddr_prbs_mchk #(.AXI_DATA_WIDTH(32), .LANE_W(16), .PRBS_ORD(7), .CNT_W(4)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .prbs_vld_i(vld), .prbs_data_i(data_a), .stat_clr(clr),
        .prbs_lock(lock_a), .prbs_err_flag(err_a), .prbs_rx_dcnt(dcnt_a), .prbs_rx_ecnt(ecnt_a));

    ddr_prbs_mchk #(.AXI_DATA_WIDTH(32), .LANE_W(16), .PRBS_ORD(15)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .prbs_vld_i(vld), .prbs_data_i(data_b), .stat_clr(clr),
        .prbs_lock(lock_b), .prbs_err_flag(err_b), .prbs_rx_dcnt(dcnt_b), .prbs_rx_ecnt(ecnt_b));

    ddr_prbs_mchk #(.AXI_DATA_WIDTH(128), .LANE_W(64), .PRBS_ORD(23)) dut_c (
        .clk_sys(clk_sys), .reset(reset), .prbs_vld_i(vld), .prbs_data_i(data_c), .stat_clr(clr),
        .prbs_lock(lock_c), .prbs_err_flag(err_c), .prbs_rx_dcnt(dcnt_c), .prbs_rx_ecnt(ecnt_c));

    ddr_prbs_mchk #(.AXI_DATA_WIDTH(128), .LANE_W(64), .PRBS_ORD(31)) dut_d (
        .clk_sys(clk_sys), .reset(reset), .prbs_vld_i(vld), .prbs_data_i(data_d), .stat_clr(clr),
        .prbs_lock(lock_d), .prbs_err_flag(err_d), .prbs_rx_dcnt(dcnt_d), .prbs_rx_ecnt(ecnt_d));

`ifdef DDR_PRBS_BITERR_EN
    localparam logic [63:0] EC3_EXP = 64'd3;
`else
    localparam logic [63:0] EC3_EXP = 64'd2;
`endif

    int unsigned l_ord [NL];
    int unsigned l_w   [NL];
    logic [63:0] l_st  [NL];
    logic [63:0] l_word[NL];
    logic [63:0] garb  [4];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Serial Fibonacci LFSR, one bit at a time; first bit lands in the word MSB.
    task automatic gen_all();
        int unsigned tap;
        logic b;
        for (int i = 0; i < NL; i++) begin
            case (l_ord[i])
                7:       tap = 6;
                15:      tap = 14;
                23:      tap = 18;
                default: tap = 28;
            endcase
            l_word[i] = '0;
            for (int unsigned k = 0; k < l_w[i]; k++) begin
                b = l_st[i][6'(l_ord[i] - 1)] ^ l_st[i][6'(tap - 1)];
                l_st[i]   = {l_st[i][62:0], b};
                l_word[i] = {l_word[i][62:0], b};
            end
        end
    endtask

    task automatic send();
        for (int i = 0; i < 16; i++) wm[i] = l_word[i][31:0];
        for (int i = 0; i < 2; i++) begin
            wa[i] = l_word[16+i][15:0];
            wb[i] = l_word[18+i][15:0];
            wc[i] = l_word[20+i];
            wd[i] = l_word[22+i];
        end
        vld = 1'b1;
        tick();
        vld = 1'b0;
    endtask

    task automatic clean_words(input int n);
        for (int i = 0; i < n; i++) begin
            gen_all();
            send();
        end
    endtask

    task automatic chk_all_locked(input string tag);
        chk({tag, "_m"}, 64'(lock_m), 64'hFFFF);
        chk({tag, "_a"}, 64'(lock_a), 64'h3);
        chk({tag, "_b"}, 64'(lock_b), 64'h3);
        chk({tag, "_c"}, 64'(lock_c), 64'h3);
        chk({tag, "_d"}, 64'(lock_d), 64'h3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NL; i++) begin
            l_ord[i] = (i < 16) ? 31 : (i < 18) ? 7 : (i < 20) ? 15 : (i < 22) ? 23 : 31;
            l_w[i]   = (i < 16) ? 32 : (i < 20) ? 16 : 64;
            l_st[i]  = 64'h0123_4567_89AB_C000 | 64'(i + 1);
        end
        garb[0] = 64'hDEAD_BEEF; garb[1] = 64'h1234_5678;
        garb[2] = 64'hCAFE_F00D; garb[3] = 64'h0BAD_C0DE;
        for (int i = 0; i < 16; i++) wm[i] = '0;
        for (int i = 0; i < 2; i++) begin wa[i] = '0; wb[i] = '0; wc[i] = '0; wd[i] = '0; end

        // Reset state
        #1 reset = 1'b0;
        #1;
        chk("rst_lock", 64'(lock_m), 64'h0);
        chk("rst_err", 64'(err_m), 64'h0);
        chk("rst_dcnt_any", 64'(|dcnt_m), 64'h0);
        chk("rst_ecnt_any", 64'(|ecnt_m), 64'h0);
        tick(); tick();
        reset = 1'b1;
        tick(); tick();

        // Acquisition: 9 valid words with an invalid garbage cycle in the middle
        clean_words(4);
        for (int i = 0; i < 16; i++) wm[i] = 32'hFFFF_0000 ^ 32'(i);
        tick();
        clean_words(4);
        chk("lock_after8", 64'(lock_m), 64'h0);
        chk("lock_a_after8", 64'(lock_a), 64'h0);
        clean_words(1);
        chk_all_locked("lock_after9");
        chk("dcnt0_lockword", 64'(dc_m[0]), 64'd0);

        // Clean stream: 100 counted words
        clean_words(100);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("clean_dcnt%0d", i), 64'(dc_m[i]), 64'd100);
            chk($sformatf("clean_ecnt%0d", i), 64'(ec_m[i]), 64'd0);
        end
        chk("clean_err", 64'(err_m), 64'h0);
        chk("sat_dcnt_a0", 64'(dc_a[0]), 64'hF);
        chk("sat_dcnt_a1", 64'(dc_a[1]), 64'hF);
        chk("clean_ecnt_bcd", 64'(|{ecnt_b, ecnt_c, ecnt_d}), 64'h0);
        chk_all_locked("clean_lock");

        // Single bit flip on lane 3 corrupts two predictions
        gen_all();
        l_word[3][5] = ~l_word[3][5];
        send();
        chk("flip_ecnt3_w1", 64'(ec_m[3]), 64'd1);
        chk("flip_err", 64'(err_m), 64'h0008);
        clean_words(2);
        chk("flip_ecnt3", 64'(ec_m[3]), EC3_EXP);
        chk("flip_dcnt3", 64'(dc_m[3]), 64'd103);
        chk("flip_ecnt2", 64'(ec_m[2]), 64'd0);
        chk("flip_lock", 64'(lock_m), 64'hFFFF);

        // Four garbage words on lane 0 drop its lock
        for (int g = 0; g < 4; g++) begin
            gen_all();
            l_word[0] = garb[g];
            send();
            if (g == 2) chk("garb3_lock", 64'(lock_m), 64'hFFFF);
        end
        chk("garb4_lock", 64'(lock_m), 64'hFFFE);
        chk("garb_dcnt0", 64'(dc_m[0]), 64'd107);
`ifdef DDR_PRBS_BITERR_EN
        chk("garb_ecnt0_ge4", 64'(ec_m[0] >= 32'd4), 64'd1);
`else
        chk("garb_ecnt0", 64'(ec_m[0]), 64'd4);
`endif
        chk("garb_err", 64'(err_m), 64'h0009);
        clean_words(8);
        chk("relock8_lock", 64'(lock_m), 64'hFFFE);
        chk("hunt_dcnt0", 64'(dc_m[0]), 64'd107);
`ifndef DDR_PRBS_BITERR_EN
        chk("hunt_ecnt0", 64'(ec_m[0]), 64'd4);
`endif
        clean_words(1);
        chk("relock9_lock", 64'(lock_m), 64'hFFFF);
        chk("relock_dcnt1", 64'(dc_m[1]), 64'd116);

        // Error counter saturation on the 4-bit instance
        for (int b = 0; b < 8; b++) begin
            gen_all();
            l_word[16][0] = ~l_word[16][0];
            send();
            clean_words(2);
`ifndef DDR_PRBS_BITERR_EN
            if (b == 0) chk("burst1_ecnt_a0", 64'(ec_a[0]), 64'd2);
`endif
        end
        chk("sat_ecnt_a0", 64'(ec_a[0]), 64'hF);
        chk("sat_dcnt_a0_hold", 64'(dc_a[0]), 64'hF);
        chk("sat_ecnt_a1", 64'(ec_a[1]), 64'd0);
        chk("sat_err_a", 64'(err_a), 64'h1);
        chk("sat_lock_a", 64'(lock_a), 64'h3);

        // stat_clr on an increment cycle: clear wins, lock retained
        gen_all();
        clr = 1'b1;
        send();
        clr = 1'b0;
        chk("clr_dcnt_any", 64'(|dcnt_m), 64'h0);
        chk("clr_ecnt_any", 64'(|ecnt_m), 64'h0);
        chk("clr_err", 64'(err_m), 64'h0);
        chk("clr_a_cnt", 64'(|{dcnt_a, ecnt_a, err_a}), 64'h0);
        chk_all_locked("clr_lock");
        clean_words(1);
        chk("postclr_dcnt5", 64'(dc_m[5]), 64'd1);
        chk("postclr_ecnt5", 64'(ec_m[5]), 64'd0);
        chk("postclr_dcnt_a0", 64'(dc_a[0]), 64'd1);

        // Asynchronous reset mid-cycle, then reset during partial sync
        #2 reset = 1'b0;
        #1;
        chk("async_rst_lock", 64'(lock_m), 64'h0);
        chk("async_rst_dcnt", 64'(|dcnt_m), 64'h0);
        tick();
        reset = 1'b1;
        clean_words(5);
        #2 reset = 1'b0;
        tick();
        reset = 1'b1;
        clean_words(8);
        chk("rst_relock8", 64'(lock_m), 64'h0);
        chk("rst_relock8_d", 64'(lock_d), 64'h0);
        clean_words(1);
        chk_all_locked("rst_relock9");
        chk("rst_relock_ecnt", 64'(|{ecnt_m, ecnt_a, ecnt_b, ecnt_c, ecnt_d}), 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
